// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter.
// State encoding, byte width, bit timing and default watchdog limit.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD
   } state_t;

   localparam int UART_BYTE_W      = 8;
   localparam int CLKS_PER_BIT     = 5208;
   localparam int DEF_TIMEOUT_CLKS = 60000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bundle plus UART_TX handshake.
// master = producers/transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);

   logic [NUM_REQ-1:0]                      req_valid;
   logic [uart_pkg::UART_BYTE_W*NUM_REQ-1:0] req_byte;
   logic [NUM_REQ-1:0]                      req_last;
   logic [NUM_REQ-1:0]                      req_ready;
   logic                                    uart_tx_dv;
   logic [uart_pkg::UART_BYTE_W-1:0]        uart_tx_byte;
   logic                                    uart_tx_active;
   logic                                    uart_tx_done;

   modport master (
      output req_valid, req_byte, req_last,
      output uart_tx_active, uart_tx_done,
      input  req_ready, uart_tx_dv, uart_tx_byte
   );

   modport slave (
      input  req_valid, req_byte, req_last,
      input  uart_tx_active, uart_tx_done,
      output req_ready, uart_tx_dv, uart_tx_byte
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick.
// Lowest index at or above ptr wins, searching upward with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int GW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      ptr,
   output logic [GW-1:0]      grant,
   output logic               found
);

   // scan from farthest to nearest so the nearest request wins
   always_comb begin
      int j;
      found = 1'b0;
      grant = '0;
      j     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            found = 1'b1;
            grant = GW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART_TX with packet lock.
// Optional watchdog on tx_done: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int  NUM_REQ      = 2,
   parameter int  TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
   localparam int GW           = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_tx_arbiter_if.slave         bus,
   output logic [GW-1:0]            grant_id,
   output logic                     busy,
   output logic                     timeout_err
);

   state_t                 state, state_nx;
   logic [GW-1:0]          rr_ptr, rr_nx, gid_nx;
   logic [GW-1:0]          win, sel;
   logic                   found, want, issue;
   logic                   lock, lock_nx;
   logic                   last_q, last_nx;
   logic                   dv_q, dv_nx;
   logic [NUM_REQ-1:0]     ready_q, ready_nx;
   logic [UART_BYTE_W-1:0] byte_q, byte_nx;

   function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
      return (g == GW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (win),
      .found (found)
   );

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   logic [TW-1:0] to_cnt;
   logic          to_hit;

   assign to_hit      = (state == WAIT) && (to_cnt == TW'(TIMEOUT_CLKS - 1));
   assign timeout_err = to_hit && !bus.uart_tx_done;

   // watchdog counts WAIT cycles, zero in every other state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              to_cnt <= '0;
      else if (state != WAIT)  to_cnt <= '0;
      else                     to_cnt <= to_cnt + 1'b1;
   end
`else
   localparam int unused_timeout = TIMEOUT_CLKS;
   assign timeout_err = 1'b0;
`endif

   // a locked packet only listens to its owner
   assign sel  = lock ? grant_id : win;
   assign want = lock ? bus.req_valid[grant_id] : found;

   // next state and next register values
   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      lock_nx  = lock;
      last_nx  = last_q;
      gid_nx   = grant_id;
      byte_nx  = byte_q;
      dv_nx    = 1'b0;
      ready_nx = '0;
      issue    = 1'b0;
      unique case (state)
         IDLE, HOLD: issue = want && !bus.uart_tx_active;
         WAIT: begin
            if (bus.uart_tx_done) begin
               if (last_q) begin
                  lock_nx  = 1'b0;
                  rr_nx    = wrap_inc(grant_id);
                  state_nx = IDLE;
               end else begin
                  lock_nx  = 1'b1;
                  state_nx = HOLD;
               end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (to_hit) begin
               lock_nx  = 1'b0;
               rr_nx    = wrap_inc(grant_id);
               state_nx = IDLE;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
      if (issue) begin
         state_nx      = WAIT;
         gid_nx        = sel;
         byte_nx       = bus.req_byte[int'(sel)*UART_BYTE_W +: UART_BYTE_W];
         last_nx       = bus.req_last[sel];
         dv_nx         = 1'b1;
         ready_nx[sel] = 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // grant, pointer, lock and transmitter-facing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         lock     <= 1'b0;
         last_q   <= 1'b0;
         grant_id <= '0;
         byte_q   <= '0;
         dv_q     <= 1'b0;
         ready_q  <= '0;
      end else begin
         rr_ptr   <= rr_nx;
         lock     <= lock_nx;
         last_q   <= last_nx;
         grant_id <= gid_nx;
         byte_q   <= byte_nx;
         dv_q     <= dv_nx;
         ready_q  <= ready_nx;
      end
   end

   assign bus.uart_tx_dv   = dv_q;
   assign bus.uart_tx_byte = byte_q;
   assign bus.req_ready    = ready_q;
   assign busy             = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random packets vs. a queue-level arbitration model.
// Directed cases for lock, active blocking, reset mid-frame, watchdog.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N  = 2;
   localparam int GW = $clog2(N);
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TO = 100;
`else
   localparam int TO = DEF_TIMEOUT_CLKS;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [GW-1:0] grant_id;
   logic          busy;
   logic          timeout_err;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [8:0] rq [N][$];
   logic [7:0] line_b [$];
   int         line_g [$];
   logic [7:0] exp_b [$];
   int         exp_g [$];
   int         mptr = 0;
   int         frame_left = 0;
   bit         auto_uart = 1'b1;
   logic       prev_dv = 1'b0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            bus.req_valid[i]        = 1'b1;
            bus.req_last[i]         = rq[i][0][8];
            bus.req_byte[8*i +: 8]  = rq[i][0][7:0];
         end else begin
            bus.req_valid[i]        = 1'b0;
            bus.req_last[i]         = 1'b0;
            bus.req_byte[8*i +: 8]  = 8'h00;
         end
      end
   endtask

   // expected line order from the arbitration rules applied to whole queues
   task automatic model_plan();
      logic [8:0] cp [N][$];
      logic [8:0] e;
      int w;
      exp_b.delete();
      exp_g.delete();
      for (int i = 0; i < N; i++) cp[i] = rq[i];
      for (int guard = 0; guard < 1000; guard++) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && cp[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
         if (w < 0) break;
         do begin
            e = cp[w].pop_front();
            exp_b.push_back(e[7:0]);
            exp_g.push_back(w);
         end while (!e[8] && cp[w].size() > 0);
         mptr = (w + 1) % N;
      end
   endtask

   // one clock: transmitter model, producer bookkeeping, per-byte checks
   task automatic step();
      @(negedge clk);
      if (bus.uart_tx_done) bus.uart_tx_done = 1'b0;
      if (frame_left > 0) begin
         frame_left--;
         if (frame_left == 0) begin
            bus.uart_tx_active = 1'b0;
            bus.uart_tx_done   = 1'b1;
         end
      end
      if (bus.uart_tx_dv) begin
         chk("dv_single", 32'(prev_dv), 32'd0);
         chk("ready_onehot", 32'(bus.req_ready), 32'd1 << grant_id);
         line_b.push_back(bus.uart_tx_byte);
         line_g.push_back(int'(grant_id));
         if (auto_uart) begin
            frame_left = $urandom_range(12, 3);
            bus.uart_tx_active = 1'b1;
         end
      end else if (bus.req_ready != '0) begin
         chk("ready_no_dv", 32'(bus.req_ready), 32'd0);
      end
      prev_dv = bus.uart_tx_dv;
      for (int i = 0; i < N; i++)
         if (bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      drive_reqs();
   endtask

   task automatic drain(string tag);
      int c = 0;
      while (c < 2000 && (busy || frame_left > 0 || bus.uart_tx_dv || pending())) begin
         step();
         c++;
      end
      chk({tag, "_drain"}, 32'(c < 2000), 32'd1);
   endtask

   task automatic run_plan(string tag);
      int c = 0;
      model_plan();
      line_b.delete();
      line_g.delete();
      drive_reqs();
      while (c < 4000 && (busy || frame_left > 0 || bus.uart_tx_dv || pending())) begin
         step();
         c++;
      end
      chk({tag, "_end"}, 32'(c < 4000), 32'd1);
      chk({tag, "_cnt"}, line_b.size(), exp_b.size());
      for (int k = 0; k < exp_b.size() && k < line_b.size(); k++) begin
         chk($sformatf("%s_byte%0d", tag, k), 32'(line_b[k]), 32'(exp_b[k]));
         chk($sformatf("%s_gid%0d", tag, k), line_g[k], exp_g[k]);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      frame_left = 0;
      bus.uart_tx_active = 1'b0;
      bus.uart_tx_done   = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      drive_reqs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      prev_dv = 1'b0;
   endtask

   initial begin
      int c;
      int np, len;
      bus.uart_tx_active = 1'b0;
      bus.uart_tx_done   = 1'b0;
      drive_reqs();
      @(negedge clk);
      chk("rst_dv", 32'(bus.uart_tx_dv), 32'd0);
      chk("rst_byte", 32'(bus.uart_tx_byte), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_to", 32'(timeout_err), 32'd0);
      do_reset();

      // single byte from requester 0
      rq[0].push_back(9'h141);
      model_plan();
      drive_reqs();
      step();
      chk("t1_dv", 32'(bus.uart_tx_dv), 32'd1);
      chk("t1_byte", 32'(bus.uart_tx_byte), 32'h41);
      chk("t1_ready", 32'(bus.req_ready), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      c = 0;
      while (c < 100 && !bus.uart_tx_done) begin step(); c++; end
      chk("t1_done_seen", 32'(c < 100), 32'd1);
      chk("t1_busy_at_done", 32'(busy), 32'd1);
      step();
      chk("t1_idle", 32'(busy), 32'd0);

      // pointer now 1: requester 1 wins a tie
      rq[0].push_back(9'h110);
      rq[1].push_back(9'h120);
      run_plan("ptr1");

      // both valid from reset
      do_reset();
      rq[0].push_back(9'h155);
      rq[1].push_back(9'h1AA);
      run_plan("both");

      // packet lock
      do_reset();
      rq[0].push_back(9'h001);
      rq[0].push_back(9'h102);
      rq[1].push_back(9'h17F);
      run_plan("lock");

      // transmitter still active in IDLE holds off the strobe
      bus.uart_tx_active = 1'b1;
      rq[0].push_back(9'h133);
      model_plan();
      drive_reqs();
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("act_hold%0d", k), 32'(bus.uart_tx_dv), 32'd0);
      end
      bus.uart_tx_active = 1'b0;
      step();
      chk("act_dv", 32'(bus.uart_tx_dv), 32'd1);
      chk("act_byte", 32'(bus.uart_tx_byte), 32'h33);
      drain("act");

      // reset in the middle of a frame
      rq[0].push_back(9'h1C3);
      drive_reqs();
      step();
      chk("mr_dv", 32'(bus.uart_tx_dv), 32'd1);
      frame_left = 30;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("mr_dv0", 32'(bus.uart_tx_dv), 32'd0);
      chk("mr_byte0", 32'(bus.uart_tx_byte), 32'd0);
      chk("mr_ready0", 32'(bus.req_ready), 32'd0);
      chk("mr_gid0", 32'(grant_id), 32'd0);
      chk("mr_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      prev_dv = 1'b0;
      rq[1].push_back(9'h1D4);
      model_plan();
      drive_reqs();
      c = 0;
      do begin
         step();
         c++;
         chk("mr_blocked", 32'(bus.uart_tx_dv), 32'd0);
      end while (bus.uart_tx_active && c < 100);
      chk("mr_stray_done", 32'(bus.uart_tx_done), 32'd1);
      chk("mr_stray_idle", 32'(busy), 32'd0);
      step();
      chk("mr_dv", 32'(bus.uart_tx_dv), 32'd1);
      chk("mr_gid", 32'(grant_id), 32'd1);
      chk("mr_byte", 32'(bus.uart_tx_byte), 32'hD4);
      drain("mr");

      // random packets
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < N; i++) begin
            np = $urandom_range(3, 0);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(3, 1);
               for (int b = 0; b < len; b++)
                  rq[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         run_plan($sformatf("rnd%0d", s));
      end

`ifdef UART_TX_ARB_TIMEOUT_EN
      // withheld tx_done trips the watchdog
      do_reset();
      auto_uart = 1'b0;
      rq[0].push_back(9'h111);
      rq[1].push_back(9'h122);
      drive_reqs();
      step();
      chk("to_dv", 32'(bus.uart_tx_dv), 32'd1);
      chk("to_gid", 32'(grant_id), 32'd0);
      c = 0;
      for (int k = 0; k < 98; k++) begin
         step();
         if (timeout_err) c++;
      end
      chk("to_early", c, 32'd0);
      step();
      chk("to_pulse", 32'(timeout_err), 32'd1);
      auto_uart = 1'b1;
      step();
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_single", 32'(timeout_err), 32'd0);
      step();
      chk("to_next_dv", 32'(bus.uart_tx_dv), 32'd1);
      chk("to_next_gid", 32'(grant_id), 32'd1);
      drain("to");
      mptr = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
